fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter placed in front of the synchronous FIFO. It lets up to NREQ independent producers share the FIFO's single write port (wr_en/din/full) with a valid/ready handshake per producer. Once a producer is granted, it keeps the port for a bounded burst, so each producer's data stays contiguous in the FIFO. The grant then rotates fairly to the next producer.

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded, contiguous bursts into a single FIFO.
// Define FIFO_ARB_ASSERT_EN to embed the protocol assertions.
module fifo_wr_arbiter #(
  parameter int DWIDTH    = 4,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW  = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id
);

  // Handshake: a beat moves on the edge where req_valid[i] && req_ready[i];
  // a producer with valid raised holds valid and data until that edge.
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t           r_state, w_state_nx;
  logic [IDW-1:0]   r_gnt, w_gnt_nx;
  logic [IDW-1:0]   r_ptr, w_ptr_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;

  logic [DWIDTH-1:0] w_data [NREQ];
  logic              w_any;
  logic [IDW-1:0]    w_winner;
  logic [IDW-1:0]    w_idx;
  logic              w_wr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
    assign w_data[gi] = req_data[gi*DWIDTH +: DWIDTH];
  end

  // Offsets scanned from farthest to nearest so the nearest valid one after ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_wr = req_valid[r_gnt] && !fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= IDW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nx   = w_winner;
          w_cnt_nx   = '0;
          w_state_nx = ST_BURST;
        end
      end
      ST_BURST: begin
        req_ready[r_gnt] = !fifo_full;
        fifo_wr_en       = w_wr;
        fifo_din         = w_data[r_gnt];
        if (w_wr) begin
          w_cnt_nx = r_cnt + 1'b1;
          if (r_cnt == CW'(MAX_BURST - 1)) begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = r_gnt;
          end
        end else if (!req_valid[r_gnt]) begin
          // Producer went quiet: give up the port rather than wait.
          w_state_nx = ST_IDLE;
          w_ptr_nx   = r_gnt;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign grant_valid = (r_state == ST_BURST);
  assign grant_id    = r_gnt;

`ifdef FIFO_ARB_ASSERT_EN
  a_no_wr_full: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_wr_en && fifo_full))
    else $error("fifo_wr_en asserted while fifo_full");
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(req_ready))
    else $error("more than one req_ready bit set");
  a_gnt_stable: assert property (@(posedge clk) disable iff (!rst)
    (r_state == ST_BURST && w_state_nx == ST_BURST) |=> $stable(r_gnt))
    else $error("grant changed inside a burst");
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    r_cnt <= CW'(MAX_BURST))
    else $error("burst counter exceeded MAX_BURST");
  a_rst_release: assert property (@(posedge clk) disable iff (!rst)
    $rose(rst) |-> !grant_valid)
    else $error("grant_valid high right after reset release");
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a behavioural round-robin model.
module tb_fifo_wr_arbiter;
  localparam int DW = 4;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic            grant_valid;
  logic [1:0]      grant_id;

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // behavioural model: who owns the port, who was served last, beats so far
  int m_owner, m_last, m_beats, m_gid;

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_beats = 0;
    m_gid   = 0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (req_valid[idx]) begin
          m_owner = idx;
          m_gid   = idx;
          m_beats = 0;
          break;
        end
      end
    end else if (req_valid[m_owner] && !fifo_full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [NR-1:0] e_ready;
    logic          e_wr;
    logic [DW-1:0] e_din;
    logic          e_gv;
    int            e_gid;
    e_ready = '0; e_wr = 1'b0; e_din = '0; e_gv = 1'b0; e_gid = m_gid;
    if (m_owner >= 0) begin
      e_gv  = 1'b1;
      e_gid = m_owner;
      if (!fifo_full) e_ready[m_owner] = 1'b1;
      e_wr  = req_valid[m_owner] && !fifo_full;
      e_din = req_data[m_owner*DW +: DW];
    end
    check({tag, ".ready"}, 32'(req_ready),   32'(e_ready));
    check({tag, ".wr_en"}, 32'(fifo_wr_en),  32'(e_wr));
    check({tag, ".din"},   32'(fifo_din),    32'(e_din));
    check({tag, ".gv"},    32'(grant_valid), 32'(e_gv));
    check({tag, ".gid"},   32'(grant_id),    32'(e_gid));
  endtask

  // scoreboard and producer state
  logic [DW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            gnt_log[$];
  logic [DW-1:0] src_mem [NR][16];
  int            src_n  [NR];
  int            src_rd [NR];
  logic [NR-1:0] hold;
  bit            rnd_mode = 1'b0;
  bit            sb_on    = 1'b0;
  bit            prev_gv  = 1'b0;
  int            cyc      = 0;

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_n[i]  = 0;
      src_rd[i] = 0;
    end
    exp_q.delete();
    wr_cyc.delete();
    gnt_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0; hold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    prev_gv = 1'b0;
  endtask

  // driver: one clock cycle, entered and left at the falling edge
  task automatic run_cycle(input bit full_v, input string tag);
    logic [NR-1:0] acc;
    for (int i = 0; i < NR; i++) begin
      if (!hold[i]) begin
        if (rnd_mode) begin
          req_valid[i] = ($urandom_range(0, 99) >= 30);
          req_data[i*DW +: DW] = DW'($urandom);
        end else begin
          req_valid[i] = (src_rd[i] < src_n[i]);
          if (req_valid[i]) req_data[i*DW +: DW] = src_mem[i][src_rd[i]];
        end
        hold[i] = req_valid[i];
      end
    end
    fifo_full = full_v;
    #1;
    compare_outputs(tag);
    if (fifo_wr_en) wr_cyc.push_back(cyc);
    if (grant_valid && !prev_gv) gnt_log.push_back(int'(grant_id));
    prev_gv = grant_valid;
    if (sb_on && fifo_wr_en) begin
      check({tag, ".sb_pending"}, 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) check({tag, ".sb_din"}, 32'(fifo_din), 32'(exp_q.pop_front()));
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    model_step();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        hold[i] = 1'b0;
        if (!rnd_mode) src_rd[i]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic [NR*DW-1:0] data;
    logic          full;
    logic [NR-1:0] e_ready;
    logic          e_wr;
    logic [DW-1:0] e_din;
    logic          e_gv;
    logic [1:0]    e_gid;
  } vec_t;

  vec_t vtab [14];

  initial begin
    // rows: reset with all valid, first burst with a 2-cycle full stall,
    // rotation to requester 1, early drop of requester 1, hand-off to 2
    vtab[0]  = '{1'b0, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
    vtab[1]  = '{1'b0, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
    vtab[2]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
    vtab[3]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0};
    vtab[4]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0};
    vtab[5]  = '{1'b1, 4'hF, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1, 2'd0};
    vtab[6]  = '{1'b1, 4'hF, 16'h4321, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1, 2'd0};
    vtab[7]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0};
    vtab[8]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0};
    vtab[9]  = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
    vtab[10] = '{1'b1, 4'hF, 16'h4321, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1};
    vtab[11] = '{1'b1, 4'hD, 16'h4321, 1'b0, 4'h2, 1'b0, 4'h2, 1'b1, 2'd1};
    vtab[12] = '{1'b1, 4'hD, 16'h4321, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1};
    vtab[13] = '{1'b1, 4'hD, 16'h4321, 1'b0, 4'h4, 1'b1, 4'h3, 1'b1, 2'd2};

    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0; hold = '0;
    @(negedge clk);
    for (int r = 0; r < 14; r++) begin
      rst = vtab[r].rst; req_valid = vtab[r].valid;
      req_data = vtab[r].data; fifo_full = vtab[r].full;
      #1;
      check($sformatf("vec%0d.ready", r), 32'(req_ready),   32'(vtab[r].e_ready));
      check($sformatf("vec%0d.wr_en", r), 32'(fifo_wr_en),  32'(vtab[r].e_wr));
      check($sformatf("vec%0d.din", r),   32'(fifo_din),    32'(vtab[r].e_din));
      check($sformatf("vec%0d.gv", r),    32'(grant_valid), 32'(vtab[r].e_gv));
      check($sformatf("vec%0d.gid", r),   32'(grant_id),    32'(vtab[r].e_gid));
      @(posedge clk);
      @(negedge clk);
    end

    // single requester 2: two bursts of 4 separated by one idle cycle
    do_reset(); clear_src(); sb_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_mem[2][k] = DW'(k + 1);
      exp_q.push_back(DW'(k + 1));
    end
    src_n[2] = 8;
    repeat (12) run_cycle(1'b0, "single");
    check("single.drained", 32'(exp_q.size()), 32'(0));
    check("single.nwr", 32'(wr_cyc.size()), 32'(8));
    if (wr_cyc.size() == 8) begin
      check("single.burst_span", 32'(wr_cyc[3] - wr_cyc[0]), 32'(3));
      check("single.idle_gap",   32'(wr_cyc[4] - wr_cyc[3]), 32'(2));
    end
    foreach (gnt_log[g]) check("single.gid", 32'(gnt_log[g]), 32'(2));

    // all four requesters valid: order 0,1,2,3,0 with grouped data
    do_reset(); clear_src();
    for (int i = 0; i < NR; i++) begin
      src_n[i] = (i == 0) ? 8 : 4;
      for (int k = 0; k < src_n[i]; k++) src_mem[i][k] = DW'(i * 4 + (k % 4));
    end
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) exp_q.push_back(DW'((b % 4) * 4 + k));
    repeat (30) run_cycle(1'b0, "rr");
    check("rr.drained", 32'(exp_q.size()), 32'(0));
    check("rr.ngrants", 32'(gnt_log.size() >= 5), 32'(1));
    for (int g = 0; g < 5 && g < gnt_log.size(); g++)
      check($sformatf("rr.order%0d", g), 32'(gnt_log[g]), 32'(g % 4));

    // full after beat 2 for three cycles, then two more beats and IDLE
    do_reset(); clear_src();
    for (int k = 0; k < 6; k++) begin
      src_mem[0][k] = DW'(k + 1);
      exp_q.push_back(DW'(k + 1));
    end
    src_n[0] = 6;
    repeat (3) run_cycle(1'b0, "full");
    check("full.pre_beats", 32'(wr_cyc.size()), 32'(2));
    repeat (3) run_cycle(1'b1, "full.stall");
    check("full.stall_beats", 32'(wr_cyc.size()), 32'(2));
    repeat (2) run_cycle(1'b0, "full");
    #1;
    check("full.end_gv", 32'(grant_valid), 32'(0));
    check("full.end_wr", 32'(fifo_wr_en), 32'(0));
    check("full.burst_beats", 32'(wr_cyc.size()), 32'(4));
    repeat (5) run_cycle(1'b0, "full");
    check("full.drained", 32'(exp_q.size()), 32'(0));
    sb_on = 1'b0;

    // reset asserted during beat 2 of a requester-3 burst
    do_reset(); clear_src();
    for (int k = 0; k < 4; k++) src_mem[3][k] = DW'(k + 9);
    src_n[3] = 4;
    repeat (2) run_cycle(1'b0, "mid");
    req_valid[3] = 1'b1; req_data[3*DW +: DW] = src_mem[3][1];
    #1;
    check("mid.wr_before", 32'(fifo_wr_en), 32'(1));
    #1 rst = 1'b0;
    #1;
    check("mid.wr_async", 32'(fifo_wr_en),  32'(0));
    check("mid.rdy_async", 32'(req_ready),  32'(0));
    check("mid.gv_async", 32'(grant_valid), 32'(0));
    check("mid.gid_async", 32'(grant_id),   32'(0));
    req_valid = '0; hold = '0;
    @(posedge clk);
    @(negedge clk);
    clear_src();
    src_n[0] = 2; src_mem[0][0] = 4'h5; src_mem[0][1] = 4'h6;
    src_n[3] = 2; src_mem[3][0] = 4'hA; src_mem[3][1] = 4'hB;
    rst = 1'b1; model_reset(); prev_gv = 1'b0;
    repeat (3) run_cycle(1'b0, "mid.after");
    check("mid.first_grant_seen", 32'(gnt_log.size() > 0), 32'(1));
    if (gnt_log.size() > 0) check("mid.first_grant", 32'(gnt_log[0]), 32'(0));

    // randomized traffic with random backpressure
    do_reset(); clear_src(); rnd_mode = 1'b1;
    for (int c = 0; c < 400; c++) run_cycle($urandom_range(0, 99) < 20, "rnd");
    rnd_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
